// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link: FSM state encoding and slot geometry.
// Imported by both the sender and the receive-side demultiplexer.
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position tracker: wraps 0..3 on each strobe.
// A sync bit forces it to 1 because that bit already occupied slot 0.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  load0,
  input  logic  clr,
  output slot_t s
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset)      s <= '0;
    else if (clr)   s <= '0;
    else if (load0) s <= slot_t'(1);
    else if (en)    s <= s + slot_t'(1);
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: acquires frame alignment from the sync
// marker, gathers one bit per slot and commits all four channels per frame.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m,
  input  logic       en,
  input  logic       sync,
  output logic       u,
  output logic       v,
  output logic       w,
  output logic       x,
  output logic [1:0] s,
  output logic       valid,
  output logic       locked,
  output logic       err
);

  tdm_state_e       state_q, state_d;
  logic [3:0]       good_q, good_d, good_inc;
  logic [SLOTS-1:0] shadow_q, shadow_d;
  logic             commit, err_d;
  logic             cnt_en, load0, clr;

  tdm_slot_counter u_slot (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .load0 (load0),
    .clr   (clr),
    .s     (s)
  );

  assign good_inc = good_q + 4'd1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches below can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    err_d    = 1'b0;
    cnt_en   = 1'b0;
    load0    = 1'b0;
    clr      = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = m;
            load0       = 1'b1;
            good_d      = '0;
            state_d     = SYNC;
          end
        end

        default: begin
          if (sync && s != 2'd0) begin
            // Early marker: abandon the partial frame and realign on this bit.
            err_d       = 1'b1;
            shadow_d[0] = m;
            load0       = 1'b1;
            good_d      = '0;
            state_d     = SYNC;
          end else if (!sync && s == 2'd0) begin
            err_d   = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
          end else begin
            shadow_d[s] = m;
            cnt_en      = 1'b1;
            if (s == 2'd3) begin
              if (state_q == LOCKED) begin
                commit = 1'b1;
              end else begin
                good_d = good_inc;
                if (good_inc == 4'(LOCK_FRAMES)) begin
                  commit  = 1'b1;
                  state_d = LOCKED;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // NOTE: the shadow bank is only four flops, so it is reset along with the
  // rest; a mid-frame reset must not leak stale bits into a later commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      good_q   <= '0;
      shadow_q <= '0;
      {u, v, w, x} <= 4'b0000;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      shadow_q <= shadow_d;
      valid    <= commit;
      err      <= err_d;
      if (commit) {u, v, w, x} <= {shadow_d[0], shadow_d[1], shadow_d[2], shadow_d[3]};
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: acquisition, gaps, early/missing sync and
// mid-frame reset, with expected values worked out by hand.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       u, v, w, x;
  logic [1:0] s;
  logic       valid, locked, err;
  logic [3:0] uvwx;

  int tests_run = 0;
  int failed = 0;

  assign uvwx = {u, v, w, x};

  always #5 clk = ~clk;

  tdm_demux4 #(.LOCK_FRAMES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .m      (m),
    .en     (en),
    .sync   (sync),
    .u      (u),
    .v      (v),
    .w      (w),
    .x      (x),
    .s      (s),
    .valid  (valid),
    .locked (locked),
    .err    (err)
  );

  task automatic send_bit(input logic bm, input logic bs);
    @(negedge clk);
    en = 1'b1; m = bm; sync = bs;
    @(posedge clk);
    #1;
    en = 1'b0; m = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    tests_run++; if (uvwx !== 4'b0000) begin failed++; $display("FAIL reset_uvwx: got %b want 0000", uvwx); end
    tests_run++; if (s !== 2'd0) begin failed++; $display("FAIL reset_s: got %0d want 0", s); end
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b want 0", err); end
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL reset_locked: got %b want 0", locked); end
  endtask

  task automatic test_lock;
    logic [3:0] f1 = 4'b1000;
    logic [3:0] f2 = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      send_bit(f1[3-i], i == 0);
      tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL lock_f1_valid slot %0d: got %b want 0", i, valid); end
    end
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL lock_f1_locked: got %b want 0", locked); end
    tests_run++; if (s !== 2'd0) begin failed++; $display("FAIL lock_f1_s: got %0d want 0", s); end
    for (int i = 0; i < 4; i++) send_bit(f2[3-i], i == 0);
    tests_run++; if (valid !== 1'b1) begin failed++; $display("FAIL lock_f2_valid: got %b want 1", valid); end
    tests_run++; if (uvwx !== 4'b0110) begin failed++; $display("FAIL lock_f2_uvwx: got %b want 0110", uvwx); end
    tests_run++; if (locked !== 1'b1) begin failed++; $display("FAIL lock_f2_locked: got %b want 1", locked); end
    tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL lock_f2_err: got %b want 0", err); end
    idle(1);
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL lock_valid_pulse: got %b want 0", valid); end
  endtask

  task automatic test_gap;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      tests_run++; if (s !== 2'd2) begin failed++; $display("FAIL gap_s idle %0d: got %0d want 2", i, s); end
    end
    send_bit(1'b0, 1'b0);
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL gap_early_valid: got %b want 0", valid); end
    tests_run++; if (uvwx !== 4'b0110) begin failed++; $display("FAIL gap_hold_uvwx: got %b want 0110", uvwx); end
    send_bit(1'b1, 1'b0);
    tests_run++; if (valid !== 1'b1) begin failed++; $display("FAIL gap_valid: got %b want 1", valid); end
    tests_run++; if (uvwx !== 4'b1101) begin failed++; $display("FAIL gap_uvwx: got %b want 1101", uvwx); end
  endtask

  task automatic test_early_sync;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    tests_run++; if (err !== 1'b1) begin failed++; $display("FAIL early_err: got %b want 1", err); end
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL early_locked: got %b want 0", locked); end
    tests_run++; if (s !== 2'd1) begin failed++; $display("FAIL early_s: got %0d want 1", s); end
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL early_valid: got %b want 0", valid); end
    tests_run++; if (uvwx !== 4'b1101) begin failed++; $display("FAIL early_uvwx: got %b want 1101", uvwx); end
    idle(1);
    tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL early_err_pulse: got %b want 0", err); end
    // Finish the realigned frame: first good frame after the error.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL early_relock1_valid: got %b want 0", valid); end
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL early_relock1_locked: got %b want 0", locked); end
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++; if (valid !== 1'b1) begin failed++; $display("FAIL early_relock2_valid: got %b want 1", valid); end
    tests_run++; if (locked !== 1'b1) begin failed++; $display("FAIL early_relock2_locked: got %b want 1", locked); end
    tests_run++; if (uvwx !== 4'b0011) begin failed++; $display("FAIL early_relock2_uvwx: got %b want 0011", uvwx); end
  endtask

  task automatic test_missing_sync;
    send_bit(1'b1, 1'b0);
    tests_run++; if (err !== 1'b1) begin failed++; $display("FAIL miss_err: got %b want 1", err); end
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL miss_locked: got %b want 0", locked); end
    tests_run++; if (s !== 2'd0) begin failed++; $display("FAIL miss_s: got %0d want 0", s); end
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL miss_valid: got %b want 0", valid); end
    tests_run++; if (uvwx !== 4'b0011) begin failed++; $display("FAIL miss_uvwx: got %b want 0011", uvwx); end
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, 1'b0);
      tests_run++; if (s !== 2'd0) begin failed++; $display("FAIL hunt_s bit %0d: got %0d want 0", i, s); end
      tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL hunt_err bit %0d: got %b want 0", i, err); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] fa = 4'b1111;
    logic [3:0] fb = 4'b1010;
    for (int i = 0; i < 4; i++) send_bit(fa[3-i], i == 0);
    for (int i = 0; i < 4; i++) send_bit(fb[3-i], i == 0);
    tests_run++; if (uvwx !== 4'b1010) begin failed++; $display("FAIL rst_pre_uvwx: got %b want 1010", uvwx); end
    tests_run++; if (locked !== 1'b1) begin failed++; $display("FAIL rst_pre_locked: got %b want 1", locked); end
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    tests_run++; if (s !== 2'd2) begin failed++; $display("FAIL rst_pre_s: got %0d want 2", s); end
    @(negedge clk);
    reset = 1'b1; en = 1'b1; m = 1'b1; sync = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (uvwx !== 4'b0000) begin failed++; $display("FAIL rst_mid_uvwx: got %b want 0000", uvwx); end
    tests_run++; if (s !== 2'd0) begin failed++; $display("FAIL rst_mid_s: got %0d want 0", s); end
    tests_run++; if (locked !== 1'b0) begin failed++; $display("FAIL rst_mid_locked: got %b want 0", locked); end
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
    tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL rst_mid_err: got %b want 0", err); end
    reset = 1'b0; en = 1'b0; m = 1'b0;
    send_bit(1'b1, 1'b0);
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL rst_after_valid: got %b want 0", valid); end
    tests_run++; if (uvwx !== 4'b0000) begin failed++; $display("FAIL rst_after_uvwx: got %b want 0000", uvwx); end
    tests_run++; if (s !== 2'd0) begin failed++; $display("FAIL rst_after_s: got %0d want 0", s); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_gap();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Sequential 1-to-4 time-division demultiplexer: the receive end of the 4:1 mux channel, whose 1-bit line `m` carries channels u, v, w, x in slots 0-3 under a 2-bit select. The block tracks the slot position from a frame-sync marker, collects one bit per slot into shadow registers, and commits all four recovered channels together at each frame end. It sits downstream of `one_bit_4to1muxV2`-style senders on the board datapath.

## Interface
- `LOCK_FRAMES`, default 2: consecutive well-formed frames required in SYNC before entering LOCKED (legal range 1-15).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `m`  in  1  serial TDM data bit.
- `en`  in  1  slot strobe; `m` and `sync` are sampled only when `en`=1.
- `sync`  in  1  frame marker; valid only with `en`; 1 means this bit is slot 0.
- `u`, `v`, `w`, `x`  out  1 each  recovered channels 0-3; registered.
- `s`  out  2  slot index of the next expected bit.
- `valid`  out  1  one-cycle pulse when u..x are updated.
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  one-cycle pulse on a framing error.

## Operation
- States: HUNT, SYNC, LOCKED. After reset: HUNT, s=0, u=v=w=x=0, shadows=0, good count=0, valid=err=locked=0.
- HUNT: with `en`=0, or `en`=1 and `sync`=0, data is discarded and s stays 0. With `en`=1 and `sync`=1, store `m` in shadow[0], set s=1, clear the good count, and go to SYNC.
- SYNC or LOCKED, `en`=1, `sync`=0, s≠0: store `m` in shadow[s] and increment s. s wraps from 3 to 0.
- Frame completion: `en` at s=3 with no error.
  - In SYNC: increment the good count. When the count reaches LOCK_FRAMES, commit shadow[0..3] to u,v,w,x, pulse `valid`, and go to LOCKED.
  - In LOCKED: commit and pulse `valid` on every frame.
  - u..x change only on a commit.
- Early sync (`en`=1, `sync`=1, s≠0):
  - Pulse `err` and discard the partial frame (no commit).
  - Treat the bit as slot 0: store it in shadow[0] and set s=1.
  - Clear the good count. State becomes SYNC; LOCKED drops to SYNC.
- Missing sync (`en`=1, `sync`=0, s=0, in SYNC or LOCKED): pulse `err`, discard the bit, go to HUNT with s=0. u..x keep their last committed values.
- Expected sync (`en`=1, `sync`=1, s=0, in SYNC or LOCKED): a normal slot-0 bit.
- `locked` = (state == LOCKED).
- `err` and `valid` are never asserted in the same cycle.

## Timing
- All outputs are registered. An `en` sampled at edge k produces s, state, err and valid values visible after edge k.
- Commit latency: the slot-3 bit sampled at edge k appears on `x` after edge k, in the same cycle as `valid`=1. u..x are stable until the next commit.
- Minimum frame is 4 consecutive `en` cycles. Gaps (`en`=0) of any length are allowed between or within frames; state and s hold during gaps.
- Back-to-back frames: slot 0 of frame N+1 may be sampled the cycle after slot 3 of frame N. `valid` pulses are then 4 cycles apart.
- `reset` has priority over all inputs, including mid-frame. It returns every output to its reset value at the next edge and discards shadows.

## Structure
- Shared package (`tdm_pkg`):
  - state encoding constants: HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2
  - `SLOTS`=4
  - slot width 2
  - Reused by the matching sender block.
- Sub-module `tdm_slot_counter`: 2-bit counter with `clk`, `reset`, `en`, `load0` (force 1 after a sync bit), and `clr` (force 0). It also supplies `s`.
- Top level holds the FSM, the good-frame counter (4 bits), the shadow registers, and the output registers.

## Test plan
- Reset, then 3 idle cycles with `en`=0 -> u..x=0, s=0, valid=err=locked=0.
- LOCK_FRAMES=2. Frames (u,v,w,x)=(1,0,0,0) then (0,1,1,0), sync on slot 0, back-to-back -> no valid after frame 1. After frame 2: valid=1 for one cycle, u..x=0,1,1,0, locked=1.
- While locked, send frame (1,1,0,1) with 2 idle cycles between slots 1 and 2 -> s holds at 2 during the gap. Commit gives u..x=1,1,0,1 with valid one cycle after the slot-3 en.
- While locked, assert sync at s=2 with m=1 -> err pulse, locked=0, s=1, u..x unchanged. Two further good frames restore locked=1.
- While locked, send a slot-0 bit with sync=0 -> err pulse, state HUNT, s=0. The next 3 non-sync bits are ignored (s stays 0).
- Assert reset at s=2 mid-frame in LOCKED -> next cycle all outputs 0 and state HUNT. The partial frame is never committed.
